// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP divider back end:
// the special-case encoding, exponent limits and the stage-1 payload.
package fp_div_pkg;

   typedef enum logic [1:0] {
      SP_NORMAL = 2'b00,
      SP_ZERO   = 2'b01,
      SP_INF    = 2'b10,
      SP_NAN    = 2'b11
   } special_e;

   localparam int          BIAS      = 127;
   localparam int          EXP_MAX   = 255;
   localparam logic [31:0] QNAN      = 32'h7FC00000;
   localparam int          EXP_W_DEF = 10;
   // One guard bit above the input exponent so +/-1 adjustments never wrap.
   localparam int          EW        = EXP_W_DEF + 1;

   typedef struct packed {
      logic                 sign;
      logic signed [EW-1:0] e;
      logic [23:0]          mant24;
      logic                 g;
      logic                 s;
      special_e             special;
   } s1_payload_t;

endpackage

// File: rtl/fp_div_norm_round_rne.sv
// Round-to-nearest-even on a normalised 24-bit significand with guard/sticky.
// A carry out means the significand rolled over to 2.0; frac is then zero.
module fp_rne_round (
   input  logic [23:0] mant24_i,
   input  logic        g_i,
   input  logic        s_i,
   output logic [22:0] frac_o,
   output logic        carry_o,
   output logic        nx_o
);

   logic up;

   assign up      = g_i & (s_i | mant24_i[0]);
   // Stored fraction wraps to zero exactly when the full significand carries out.
   assign frac_o  = mant24_i[22:0] + {22'b0, up};
   assign carry_o = up & (&mant24_i);
   assign nx_o    = g_i | s_i;

endmodule

// File: rtl/fp_div_norm_round.sv
// Two-stage normalise / round / pack back end of the binary32 divider with
// a valid/ready handshake and full backpressure. Subnormals flush to zero.
module fp_div_norm_round
   import fp_div_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int QW    = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [QW-1:0]    in_q,
   input  logic             in_rem_nz,
   input  logic [1:0]       in_special,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_ovf,
   output logic             out_unf,
   output logic             out_nx
);

   localparam logic signed [EW-1:0] E_ONE  = 1;
   localparam logic signed [EW-1:0] E_ZERO = 0;
   localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);

   logic                 s1_valid_q, s2_valid_q;
   logic                 s1_adv, s2_adv;
   s1_payload_t          s1_q, s1_d;
   logic signed [EW-1:0] exp_ext;

   logic [31:0]          res_q, res_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d, nx_q, nx_d;

   logic [22:0]          rnd_frac;
   logic                 rnd_carry, rnd_nx;
   logic signed [EW-1:0] e2;

   assign s2_adv   = !s2_valid_q | out_ready;
   assign s1_adv   = !s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   assign exp_ext  = EW'($signed(in_exp));

   // Stage 1: pick the leading one of the quotient, derive guard and sticky.
   always_comb begin
      s1_d         = '0;
      s1_d.sign    = in_sign;
      s1_d.special = special_e'(in_special);
      if (in_q[QW-1]) begin
         s1_d.mant24 = in_q[QW-1:QW-24];
         s1_d.g      = in_q[1];
         s1_d.s      = in_q[0] | in_rem_nz;
         s1_d.e      = exp_ext;
      end else begin
         s1_d.mant24 = in_q[QW-2:QW-25];
         s1_d.g      = in_q[0];
         s1_d.s      = in_rem_nz;
         s1_d.e      = exp_ext - E_ONE;
      end
   end

   fp_rne_round u_rne (
      .mant24_i (s1_q.mant24),
      .g_i      (s1_q.g),
      .s_i      (s1_q.s),
      .frac_o   (rnd_frac),
      .carry_o  (rnd_carry),
      .nx_o     (rnd_nx)
   );

   assign e2 = $signed(s1_q.e) + $signed({{(EW-1){1'b0}}, rnd_carry});

   // Stage 2: range check after rounding, then pack; specials bypass rounding.
   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      nx_d  = 1'b0;
      case (s1_q.special)
         SP_ZERO: res_d = {s1_q.sign, 31'h0};
         SP_INF:  res_d = {s1_q.sign, 8'hFF, 23'h0};
         SP_NAN:  res_d = QNAN;
         default: begin
            if (e2 >= E_MAX) begin
               res_d = {s1_q.sign, 8'hFF, 23'h0};
               ovf_d = 1'b1;
               nx_d  = 1'b1;
            end else if (e2 <= E_ZERO) begin
               res_d = {s1_q.sign, 31'h0};
               unf_d = 1'b1;
               nx_d  = 1'b1;
            end else begin
               res_d = {s1_q.sign, e2[7:0], rnd_frac};
               nx_d  = rnd_nx;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         nx_q       <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               res_q <= res_d;
               ovf_q <= ovf_d;
               unf_q <= unf_d;
               nx_q  <= nx_d;
            end
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = res_q;
   assign out_ovf    = ovf_q;
   assign out_unf    = unf_q;
   assign out_nx     = nx_q;

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Directed and randomised checks of fp_div_norm_round against an arithmetic
// reference that rounds by comparing the dropped tail with one half ULP.
module tb_fp_div_norm_round;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [25:0] in_q;
   logic        in_rem_nz;
   logic [1:0]  in_special;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_unf;
   logic        out_nx;

   int          checks = 0;
   int          errors = 0;
   logic [34:0] exp_q[$];
   int          id_q[$];
   int          beat_id = 0;
   int          pops = 0;
   logic        use_ovr;
   logic [34:0] ovr_val;
   logic        last_acc;
   logic        rand_rdy;

   fp_div_norm_round #(.EXP_W(10), .QW(26)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_q       (in_q),
      .in_rem_nz  (in_rem_nz),
      .in_special (in_special),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf),
      .out_nx     (out_nx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   // Result word followed by {ovf, unf, nx}.
   function automatic logic [34:0] model(logic sg, int ex, logic [25:0] q,
                                         logic rnz, logic [1:0] sp);
      int     n;
      int     e;
      longint keep;
      longint rem;
      longint half;
      logic   up;
      logic   nx;
      if (sp == 2'b01) return {sg, 31'h0, 3'b000};
      if (sp == 2'b10) return {sg, 8'hFF, 23'h0, 3'b000};
      if (sp == 2'b11) return {32'h7FC00000, 3'b000};
      n    = q[25] ? 2 : 1;
      e    = q[25] ? ex : ex - 1;
      keep = longint'(q) >> n;
      rem  = longint'(q) & ((longint'(1) << n) - 1);
      half = longint'(1) << (n - 1);
      up   = (rem > half) || ((rem == half) && (rnz || keep[0]));
      nx   = (rem != 0) || rnz;
      if (up) keep = keep + 1;
      if (keep == (longint'(1) << 24)) begin
         keep = longint'(1) << 23;
         e    = e + 1;
      end
      if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b101};
      if (e <= 0)   return {sg, 31'h0, 3'b011};
      return {sg, e[7:0], keep[22:0], 2'b00, nx};
   endfunction

   task automatic check(string tag, logic [34:0] obs, logic [34:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Negedge half: retire outputs against the scoreboard, then log accepted beats.
   task automatic to_neg();
      int id;
      @(negedge clk);
      last_acc = 1'b0;
      if (!rst) begin
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_out observed=%h expected=none",
                      {out_result, out_ovf, out_unf, out_nx});
            end
            if (exp_q.size() != 0) begin
               id = id_q.pop_front();
               pops++;
               check($sformatf("beat%0d", id),
                     {out_result, out_ovf, out_unf, out_nx}, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(use_ovr ? ovr_val
                            : model(in_sign, int'($signed(in_exp)), in_q, in_rem_nz, in_special));
            id_q.push_back(beat_id);
            beat_id++;
            last_acc = 1'b1;
         end
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic cycle();
      to_neg();
      to_pos();
   endtask

   task automatic drive_beat(logic sg, int ex, logic [25:0] q, logic rnz,
                             logic [1:0] sp, logic ovr, logic [34:0] ovrv);
      in_valid   = 1'b1;
      in_sign    = sg;
      in_exp     = ex[9:0];
      in_q       = q;
      in_rem_nz  = rnz;
      in_special = sp;
      use_ovr    = ovr;
      ovr_val    = ovrv;
   endtask

   task automatic send(logic sg, int ex, logic [25:0] q, logic rnz,
                       logic [1:0] sp, logic ovr, logic [34:0] ovrv);
      logic acc;
      drive_beat(sg, ex, q, rnz, sp, ovr, ovrv);
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++) begin
         cycle();
         acc = last_acc;
      end
      check("accept_timeout", {34'b0, acc}, 35'd1);
      in_valid = 1'b0;
      use_ovr  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) cycle();
      check("drain_left", 35'(exp_q.size()), 35'd0);
   endtask

   initial begin
      logic [31:0] saved;
      int          p0;
      int          ex;
      int          r;
      logic [25:0] q;
      logic [1:0]  sp;

      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_q = '0;
      in_rem_nz = 1'b0; in_special = 2'b00; out_ready = 1'b0;
      use_ovr = 1'b0; ovr_val = '0; last_acc = 1'b0; rand_rdy = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      check("rst_out_valid", {34'b0, out_valid}, 35'd0);
      check("rst_result", {out_result, out_ovf, out_unf, out_nx}, 35'd0);
      check("rst_in_ready", {34'b0, in_ready}, 35'd1);

      // Directed values, back to back with the consumer always ready.
      out_ready = 1'b1;
      send(0, 128, 26'h2000000, 0, 2'b00, 1, {32'h40000000, 3'b000});
      send(0, 127, 26'h1555555, 1, 2'b00, 1, {32'h3F2AAAAB, 3'b001});
      send(0, 127, 26'h3FFFFFF, 0, 2'b00, 1, {32'h40000000, 3'b001});
      send(0, 127, 26'h2000002, 0, 2'b00, 1, {32'h3F800000, 3'b001});
      send(0, 300, 26'h2000000, 0, 2'b00, 1, {32'h7F800000, 3'b101});
      send(1, 0,   26'h1000000, 0, 2'b00, 1, {32'h80000000, 3'b011});
      send(1, 5,   26'h0000000, 0, 2'b11, 1, {32'h7FC00000, 3'b000});
      send(1, 5,   26'h2000000, 1, 2'b01, 1, {32'h80000000, 3'b000});
      send(0, 5,   26'h2000000, 1, 2'b10, 1, {32'h7F800000, 3'b000});
      send(0, 1,   26'h2000000, 0, 2'b00, 1, {32'h00800000, 3'b000});
      send(0, 254, 26'h3FFFFFF, 0, 2'b00, 1, {32'h7F800000, 3'b101});
      send(0, 255, 26'h2000000, 0, 2'b00, 1, {32'h7F800000, 3'b101});
      send(1, 1,   26'h1FFFFFF, 1, 2'b00, 1, {32'h80800000, 3'b001});
      drain();

      // Backpressure: two beats fill the pipe, the third must wait.
      out_ready = 1'b0;
      send(0, 130, 26'h2400000, 0, 2'b00, 0, '0);
      send(1, 120, 26'h1800001, 1, 2'b00, 0, '0);
      drive_beat(0, 140, 26'h3000003, 0, 2'b00, 0, '0);
      cycle();
      check("bp_third_accepted", {34'b0, last_acc}, 35'd0);
      check("bp_in_ready", {34'b0, in_ready}, 35'd0);
      check("bp_out_valid", {34'b0, out_valid}, 35'd1);
      saved = out_result;
      cycle();
      cycle();
      check("bp_stable", {3'b0, out_result}, {3'b0, saved});
      out_ready = 1'b1;
      p0 = pops;
      cycle();
      check("bp_third_accept_on_release", {34'b0, last_acc}, 35'd1);
      in_valid = 1'b0;
      cycle();
      check("bp_consecutive_pops", 35'(pops - p0), 35'd2);
      drain();

      // Reset with two beats in flight: nothing may come out afterwards.
      out_ready = 1'b0;
      send(0, 100, 26'h2AAAAAA, 1, 2'b00, 0, '0);
      send(1, 110, 26'h1333333, 0, 2'b00, 0, '0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      id_q.delete();
      check("midrst_out_valid", {34'b0, out_valid}, 35'd0);
      check("midrst_result", {out_result, out_ovf, out_unf, out_nx}, 35'd0);
      check("midrst_in_ready", {34'b0, in_ready}, 35'd1);
      out_ready = 1'b1;
      repeat (5) cycle();

      // Randomised beats with a randomly stalling consumer.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      ex = int'($urandom_range(0, 767)) - 256;
         else if (r == 1) ex = int'($urandom_range(0, 3));
         else if (r == 2) ex = int'($urandom_range(252, 257));
         else             ex = int'($urandom_range(1, 254));
         q = 26'($urandom);
         if ($urandom_range(0, 1) == 1) q[25] = 1'b1;
         else begin q[25] = 1'b0; q[24] = 1'b1; end
         sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send(1'($urandom_range(0, 1)), ex, q, 1'($urandom_range(0, 1)), sp, 0, '0);
         if ($urandom_range(0, 3) == 0) cycle();
      end
      drain();
      rand_rdy = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_div_norm_round.md
Name: fp_div_norm_round

Overview:
- Downstream stage of the single-precision FP divider; consumes the raw quotient and remainder of the binary_division mantissa divider, plus the upstream sign/exponent/special-case results.
- Normalises, rounds (round-to-nearest-even) and packs the IEEE-754 binary32 result; flushes subnormals to zero.
- 2-stage pipeline with valid/ready handshake and full backpressure; result feeds the ALU result mux.

Parameters:
- EXP_W, 10, width of signed biased exponent input (ea - eb + 127); must hold -256..511.
- QW, 26, quotient width; value = q_mant * 2^-25, in [0.5, 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_sign  input  1  result sign (sa ^ sb)
- in_exp  input  EXP_W  signed biased exponent before normalisation
- in_q  input  QW  mantissa quotient
- in_rem_nz  input  1  divider remainder non-zero
- in_special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  32  packed binary32
- out_ovf  output  1  overflow flag
- out_unf  output  1  underflow/flush flag
- out_nx  output  1  inexact flag

Behaviour:
- Reset: out_valid=0, out_result=0, all flags 0, both stage valids 0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight beats.
- Handshake: a beat transfers when valid&ready on the same edge. Stage-2 advance = !s2_valid | out_ready; stage-1 advance = !s1_valid | stage-2 advance; in_ready = stage-1 advance (combinational, no dependence on in_valid). Outputs are held stable while out_valid & !out_ready. Order preserved.
- Latency 2 cycles with no stall; throughput 1 beat/cycle; holds 2 beats max.
- Stage 1 (normalise): if in_q[25]=1, mant24=in_q[25:2], G=in_q[1], S=in_q[0]|in_rem_nz, e=in_exp. Else mant24=in_q[24:1], G=in_q[0], S=in_rem_nz, e=in_exp-1. in_q[25:24]=00 is illegal; the bench asserts it never occurs on normal beats.
- Stage 2 (round/pack): up=G&(S|mant24[0]); m=mant24+up (25 bits). If m[24] then frac=0 and e=e+1, else frac=m[22:0]. nx=G|S.
- Range after rounding: e>=255 -> {sign,8'hFF,23'h0}, ovf=1, nx=1. e<=0 -> {sign,31'h0}, unf=1, nx=1 (flush, no subnormals). Otherwise {sign,e[7:0],frac}.
- Specials bypass rounding; all flags 0: zero -> {sign,31'h0}; inf -> {sign,8'hFF,23'h0}; NaN -> 32'h7FC00000 (sign ignored).
- Exponent arithmetic uses EXP_W+1-bit signed intermediates; no wrap.

Decomposition:
- Package fp_div_pkg holds the special-case enum (SP_NORMAL/SP_ZERO/SP_INF/SP_NAN), BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and a packed stage-1 payload struct (sign, e, mant24, G, S, special).
- One sub-module, fp_rne_round: combinational mant24/G/S -> rounded frac + carry-out + nx. Instantiated in stage 2.

Test Plan:
- 6.0/3.0: in_q=26'h2000000, rem_nz=0, exp=128, sign=0 -> after 2 cycles out_result=32'h40000000, flags 000.
- 1.0/1.5: in_q=26'h1555555, rem_nz=1, exp=127 -> 32'h3F2AAAAB, nx=1.
- Rounding carry: in_q=26'h3FFFFFF, rem_nz=0, exp=127 -> 32'h40000000, nx=1; tie case in_q=26'h2000002, rem_nz=0 -> rounds to even, frac LSB 0, 32'h3F800000 with exp=127, nx=1.
- Range: exp=300, sign=0 -> 32'h7F800000, ovf=1, nx=1; exp=0 with in_q[25]=0, sign=1 -> 32'h80000000, unf=1; special=11 -> 32'h7FC00000, flags 0.
- Backpressure: out_ready=0, drive 3 back-to-back beats -> only 2 accepted, in_ready=0 afterwards, out_result stable; raise out_ready -> 2 results in order on consecutive cycles, then 3rd accepted.
- Reset mid-flight: 2 beats in pipe, assert rst one cycle -> out_valid=0 next cycle, no stale result ever emitted.
